// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and length width.
// IMEM_LOADER_CHECKSUM_EN adds the CHK state.
package imem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    LEN0 = 3'd0,
    LEN1 = 3'd1,
    DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK  = 3'd3,
`endif
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs little-endian stream bytes into 32-bit words; word_valid_o fires with the 4th byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        accept_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_q;
  logic [23:0] sr_q;

  // Bytes 0..2 shift in from the top so byte 0 ends up in the LSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= 2'd0;
      sr_q   <= 24'd0;
    end else if (clear_i) begin
      lane_q <= 2'd0;
      sr_q   <= 24'd0;
    end else if (accept_i) begin
      lane_q <= lane_q + 2'd1;
      sr_q   <= {data_i, sr_q[23:8]};
    end
  end

  assign word_o       = {data_i, sr_q};
  assign word_valid_o = accept_i && !clear_i && (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader driving the instruction-memory write port.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e POST = CHK;
`else
  localparam state_e POST = RUN;
`endif
  localparam logic [LEN_W:0] CAP = (LEN_W+1)'(1) << ADDR_W;

  state_e             state_q, state_d;
  logic [7:0]         len_lo_q;
  logic [LEN_W-1:0]   len_q, cnt_q, cnt_d;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wd_q;
  logic               accept, too_big, last_word, wvalid;
  logic [LEN_W-1:0]   len_n;
  logic [31:0]        word;

  assign accept    = in_valid && in_ready && !start;
  assign len_n     = {in_data, len_lo_q};
  assign too_big   = {1'b0, len_n} > CAP;
  assign last_word = wvalid && ((cnt_q + 16'd1) == len_q);

  byte_packer u_pack (
    .clk          (clk),
    .rst          (rst),
    .data_i       (in_data),
    .accept_i     (accept && (state_q == DATA)),
    .clear_i      (start),
    .word_o       (word),
    .word_valid_o (wvalid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          csum_q <= 8'd0;
    else if (start)                   csum_q <= 8'd0;
    else if (accept && state_q != CHK) csum_q <= csum_q ^ in_data;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LEN0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = LEN0;
    end else begin
      case (state_q)
        LEN0: if (accept) state_d = LEN1;
        LEN1: if (accept) begin
          if (too_big)              state_d = ERR;
          else if (len_n == 16'd0)  state_d = POST;
          else                      state_d = DATA;
        end
        DATA: if (last_word) state_d = POST;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK:  if (accept) state_d = (in_data == csum_q) ? RUN : ERR;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // Release waits out the final write pulse so the CPU never sees a half-written image.
  always_comb begin
    in_ready = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
               || (state_q == CHK)
`endif
               ;
    cpu_rst  = (state_q != RUN) || mem_we_q;
    done     = (state_q == RUN) && !mem_we_q;
    err      = (state_q == ERR);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start)       cnt_d = '0;
    else if (wvalid) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo_q   <= 8'd0;
      len_q      <= '0;
      cnt_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      mem_we_q <= wvalid;
      if (wvalid) begin
        mem_wd_q   <= word;
        mem_addr_q <= cnt_q[ADDR_W-1:0];
      end
      if (accept && state_q == LEN0) len_lo_q <= in_data;
      if (accept && state_q == LEN1) len_q    <= len_n;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;

endmodule
